// File: rtl/esp32_prog_sequencer.sv
// ESP32 reset / bootloader-entry sequencer driving the nDTR/nRTS pair into the
// existing DTR/RTS -> EN/GPIO0 decoder; transparent to the host lines when idle.
module esp32_prog_sequencer #(
    parameter int C_reset_cycles = 2500000,
    parameter int C_boot_cycles  = 1250000,
    parameter int C_gap_cycles   = 250000
) (
    input  logic clk_25mhz,
    input  logic reset,
    input  logic req_boot,
    input  logic req_run,
    input  logic host_ndtr,
    input  logic host_nrts,
    output logic ndtr,
    output logic nrts,
    output logic busy,
    output logic done
);
    localparam int C_max_ab = (C_reset_cycles > C_boot_cycles) ? C_reset_cycles : C_boot_cycles;
    localparam int C_max    = (C_max_ab > C_gap_cycles) ? C_max_ab : C_gap_cycles;
    localparam int C_cnt_w  = (C_max > 1) ? $clog2(C_max) : 1;

    localparam logic [C_cnt_w-1:0] C_rst_load  = C_cnt_w'(C_reset_cycles - 1);
    localparam logic [C_cnt_w-1:0] C_boot_load = C_cnt_w'(C_boot_cycles - 1);
    localparam logic [C_cnt_w-1:0] C_gap_load  = C_cnt_w'(C_gap_cycles - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RST  = 2'd1;
    localparam logic [1:0] S_BOOT = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]         r_state;
    logic [C_cnt_w-1:0] r_cnt;
    logic               r_mode_boot;
    logic               r_ndtr;
    logic               r_nrts;
    logic               r_busy;
    logic               r_done;
    logic               w_expired;

    assign w_expired = (r_cnt == '0);

    // Both output bits live in one register pair updated on the same edge,
    // so the decoder never sees an intermediate 11/00 between phases.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mode_boot <= 1'b0;
            r_ndtr      <= 1'b1;
            r_nrts      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_boot || req_run) begin
                        r_state     <= S_RST;
                        r_cnt       <= C_rst_load;
                        r_mode_boot <= req_boot;
                        r_ndtr      <= 1'b1;
                        r_nrts      <= 1'b0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_ndtr <= host_ndtr;
                        r_nrts <= host_nrts;
                    end
                end
                S_RST: begin
                    if (!w_expired) begin
                        r_cnt <= r_cnt - C_cnt_w'(1);
                    end else if (r_mode_boot) begin
                        r_state <= S_BOOT;
                        r_cnt   <= C_boot_load;
                        r_ndtr  <= 1'b0;
                        r_nrts  <= 1'b1;
                    end else begin
                        r_state <= S_GAP;
                        r_cnt   <= C_gap_load;
                        r_ndtr  <= 1'b1;
                        r_nrts  <= 1'b1;
                    end
                end
                S_BOOT: begin
                    if (!w_expired) begin
                        r_cnt <= r_cnt - C_cnt_w'(1);
                    end else begin
                        r_state <= S_GAP;
                        r_cnt   <= C_gap_load;
                        r_ndtr  <= 1'b1;
                        r_nrts  <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (!w_expired) begin
                        r_cnt <= r_cnt - C_cnt_w'(1);
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ndtr  <= host_ndtr;
                        r_nrts  <= host_nrts;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ndtr = r_ndtr;
    assign nrts = r_nrts;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_esp32_prog_sequencer.sv
// Self-checking bench for esp32_prog_sequencer: directed scenarios plus random
// traffic, compared cycle by cycle against a phase-queue reference model.
module tb_esp32_prog_sequencer;
    localparam int C_R = 4;
    localparam int C_B = 3;
    localparam int C_G = 2;

    logic clk_25mhz = 1'b0;
    logic reset     = 1'b1;
    logic req_boot  = 1'b0;
    logic req_run   = 1'b0;
    logic host_ndtr = 1'b1;
    logic host_nrts = 1'b1;
    logic ndtr, nrts, busy, done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model: queue of expected {ndtr,nrts,busy,done} for the remaining busy cycles.
    logic [3:0] mq[$];
    logic       m_done_pend = 1'b0;

    esp32_prog_sequencer #(
        .C_reset_cycles(C_R),
        .C_boot_cycles (C_B),
        .C_gap_cycles  (C_G)
    ) dut (
        .clk_25mhz(clk_25mhz),
        .reset    (reset),
        .req_boot (req_boot),
        .req_run  (req_run),
        .host_ndtr(host_ndtr),
        .host_nrts(host_nrts),
        .ndtr     (ndtr),
        .nrts     (nrts),
        .busy     (busy),
        .done     (done)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic model_reset();
        mq.delete();
        m_done_pend = 1'b0;
    endtask

    task automatic model_step(input logic rb, input logic rr, input logic hd, input logic hr,
                              output logic [3:0] e);
        if (mq.size() > 0) begin
            e = mq.pop_front();
            if (mq.size() == 0) m_done_pend = 1'b1;
        end else if (m_done_pend) begin
            e = {hd, hr, 1'b0, 1'b1};
            m_done_pend = 1'b0;
        end else if (rb || rr) begin
            for (int i = 0; i < C_R; i++) mq.push_back(4'b1010);
            if (rb) for (int i = 0; i < C_B; i++) mq.push_back(4'b0110);
            for (int i = 0; i < C_G; i++) mq.push_back(4'b1110);
            e = mq.pop_front();
        end else begin
            e = {hd, hr, 2'b00};
        end
    endtask

    // Apply inputs for one cycle, advance the model, and return the expected
    // outputs sampled 1 time unit after the edge.
    task automatic tick(input logic rb, input logic rr, input logic hd, input logic hr,
                        output logic [3:0] e);
        req_boot  = rb;
        req_run   = rr;
        host_ndtr = hd;
        host_nrts = hr;
        model_step(rb, rr, hd, hr, e);
        @(posedge clk_25mhz);
        #1;
        req_boot = 1'b0;
        req_run  = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        reset     = 1'b1;
        host_ndtr = 1'b1;
        host_nrts = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_25mhz);
        #1;
        total_cnt++;
        if ({ndtr, nrts, busy, done} !== 4'b1100)
            $display("FAIL reset_hold: got %b want 1100", {ndtr, nrts, busy, done});
        else pass_cnt++;
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0, e);
        total_cnt++;
        if ({ndtr, nrts, busy, done} !== e)
            $display("FAIL reset_release: got %b want %b", {ndtr, nrts, busy, done}, e);
        else pass_cnt++;
    endtask

    task automatic test_boot();
        logic [3:0] e;
        int busy_n = 0;
        int done_at = -1;
        for (int i = 1; i <= 12; i++) begin
            tick(i == 1, 1'b0, 1'b0, 1'b1, e);
            total_cnt++;
            if ({ndtr, nrts, busy, done} !== e)
                $display("FAIL boot_cycle%0d: got %b want %b", i, {ndtr, nrts, busy, done}, e);
            else pass_cnt++;
            if (busy) busy_n++;
            if (done && done_at < 0) done_at = i;
        end
        total_cnt++;
        if (busy_n !== C_R + C_B + C_G) $display("FAIL boot_busy_len: got %0d want %0d", busy_n, C_R + C_B + C_G);
        else pass_cnt++;
        total_cnt++;
        if (done_at !== C_R + C_B + C_G + 1) $display("FAIL boot_done_at: got %0d want %0d", done_at, C_R + C_B + C_G + 1);
        else pass_cnt++;
    endtask

    task automatic test_run();
        logic [3:0] e;
        int busy_n = 0;
        int done_at = -1;
        for (int i = 1; i <= 9; i++) begin
            tick(1'b0, i == 1, 1'b1, 1'b1, e);
            total_cnt++;
            if ({ndtr, nrts, busy, done} !== e)
                $display("FAIL run_cycle%0d: got %b want %b", i, {ndtr, nrts, busy, done}, e);
            else pass_cnt++;
            if (busy) busy_n++;
            if (done && done_at < 0) done_at = i;
        end
        total_cnt++;
        if (busy_n !== C_R + C_G) $display("FAIL run_busy_len: got %0d want %0d", busy_n, C_R + C_G);
        else pass_cnt++;
        total_cnt++;
        if (done_at !== C_R + C_G + 1) $display("FAIL run_done_at: got %0d want %0d", done_at, C_R + C_G + 1);
        else pass_cnt++;
    endtask

    task automatic test_both_and_ignored();
        logic [3:0] e;
        for (int i = 1; i <= 12; i++) begin
            tick(i == 1, (i == 1) || (i == 2) || (i == 8), 1'b0, 1'b0, e);
            total_cnt++;
            if ({ndtr, nrts, busy, done} !== e)
                $display("FAIL both_cycle%0d: got %b want %b", i, {ndtr, nrts, busy, done}, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, (i == 1) || (i == C_R + C_G + 2), 1'b0, 1'b1, e);
            total_cnt++;
            if ({ndtr, nrts, busy, done} !== e)
                $display("FAIL b2b_cycle%0d: got %b want %b", i, {ndtr, nrts, busy, done}, e);
            else pass_cnt++;
            if (i == C_R + C_G + 2) begin
                total_cnt++;
                if ({ndtr, nrts, busy} !== 3'b101)
                    $display("FAIL b2b_restart: got %b want 101", {ndtr, nrts, busy});
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid_boot();
        logic [3:0] e;
        for (int i = 1; i <= 6; i++) begin
            tick(i == 1, 1'b0, 1'b1, 1'b0, e);
            total_cnt++;
            if ({ndtr, nrts, busy, done} !== e)
                $display("FAIL midrst_cycle%0d: got %b want %b", i, {ndtr, nrts, busy, done}, e);
            else pass_cnt++;
        end
        #5 reset = 1'b1;
        #1;
        total_cnt++;
        if ({ndtr, nrts, busy, done} !== 4'b1100)
            $display("FAIL midrst_async: got %b want 1100", {ndtr, nrts, busy, done});
        else pass_cnt++;
        model_reset();
        @(posedge clk_25mhz);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, i[0], ~i[1], e);
            total_cnt++;
            if ({ndtr, nrts, busy, done} !== e)
                $display("FAIL midrst_after%0d: got %b want %b", i, {ndtr, nrts, busy, done}, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [3:0] e;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
            total_cnt++;
            if ({ndtr, nrts, busy, done} !== e)
                $display("FAIL random_cycle%0d: got %b want %b", i, {ndtr, nrts, busy, done}, e);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_run();
        test_both_and_ignored();
        test_back_to_back();
        test_reset_mid_boot();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
